// File: rtl/vme_ram_reader.sv
// vme_ram_reader: VME-side reader of the capture RAM.
// Snoops the write stage's wr_ena/wr_addr stream to learn where an event
// starts and how long it is. After capture ends it serves single-word VME
// reads in capture order, wrapping through the 4096-word address space.
// Optional feature: define RD_CHECKSUM_EN to build the running 16-bit sum of
// delivered words. Without it, checksum is tied to zero.
// RAM_LAT is the RAM read latency and must be 1 or 2.

module vme_ram_reader #(
    parameter int DATA_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ena,
    input  logic [11:0]       wr_addr,
    output logic [11:0]       rd_addr,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              vme_rd,
    input  logic              vme_clr,
    output logic [DATA_W-1:0] vme_data,
    output logic              vme_ack,
    output logic              buf_full,
    output logic              busy,
    output logic [12:0]       words_left,
    output logic              err,
    output logic [15:0]       checksum
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        READY,
        FETCH,
        DONE
    } state_t;

    localparam logic [12:0] CNT_MAX = 13'd4096;
    localparam logic [1:0]  LAT_END = 2'(RAM_LAT);

    state_t      state;
    logic [11:0] first_addr;
    logic [12:0] cnt;
    logic [1:0]  lat_cnt;

`ifdef RD_CHECKSUM_EN
    logic [15:0] sum_r;

    assign checksum = sum_r;
`else
    assign checksum = 16'h0000;
`endif

    // Capture/readout state machine; every output is a register written here.
    // Reset and a VME clear both return the block to an empty IDLE.
    always_ff @(posedge clk) begin
        if (!rst || vme_clr) begin
            state      <= IDLE;
            first_addr <= '0;
            cnt        <= '0;
            lat_cnt    <= '0;
            rd_addr    <= '0;
            vme_data   <= '0;
            vme_ack    <= 1'b0;
            buf_full   <= 1'b0;
            busy       <= 1'b0;
            words_left <= '0;
            err        <= 1'b0;
`ifdef RD_CHECKSUM_EN
            sum_r      <= '0;
`endif
        end else begin
            vme_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (vme_rd) begin
                        vme_ack  <= 1'b1;
                        vme_data <= '0;
                        err      <= 1'b1;
                    end
                    if (wr_ena) begin
                        state      <= CAPTURE;
                        first_addr <= wr_addr;
                        cnt        <= 13'd1;
                        busy       <= 1'b1;
`ifdef RD_CHECKSUM_EN
                        sum_r      <= '0;
`endif
                    end
                end

                CAPTURE: begin
                    if (vme_rd) begin
                        err <= 1'b1;
                    end
                    if (wr_ena) begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 13'd1;
                        end
                    end else begin
                        state      <= READY;
                        busy       <= 1'b0;
                        words_left <= cnt;
                        rd_addr    <= first_addr;
                        buf_full   <= (cnt != 13'd0);
                    end
                end

                READY: begin
                    if (wr_ena) begin
                        err <= 1'b1;
                    end
                    if (vme_rd) begin
                        state   <= FETCH;
                        lat_cnt <= '0;
                    end
                end

                FETCH: begin
                    if (wr_ena || vme_rd) begin
                        err <= 1'b1;
                    end
                    if (lat_cnt == LAT_END) begin
                        vme_ack    <= 1'b1;
                        vme_data   <= ram_q;
                        rd_addr    <= rd_addr + 12'd1;
                        words_left <= words_left - 13'd1;
`ifdef RD_CHECKSUM_EN
                        sum_r      <= sum_r + 16'(ram_q);
`endif
                        if (words_left == 13'd1) begin
                            state    <= DONE;
                            buf_full <= 1'b0;
                        end else begin
                            state <= READY;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end

                DONE: begin
                    if (vme_rd) begin
                        vme_ack  <= 1'b1;
                        vme_data <= '0;
                        err      <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vme_ram_reader.md
# vme_ram_reader

Downstream VME-side consumer of the capture RAM write stage. It monitors the write-enable/address stream driven into the capture RAM to learn where an event starts and how many words it has. Once capture finishes, it serves single-word VME reads from the RAM's read port in capture order, wrapping through the 4096-word address space. It reports occupancy and a sticky protocol-error flag, and is re-armed by a VME clear.

## Interface

Parameters:
- DATA_W, 16, RAM word width
- RAM_LAT, 1, RAM read latency in cycles from rd_addr to ram_q (legal values 1 or 2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- wr_ena  in  1  capture RAM write enable from the write stage
- wr_addr  in  12  capture RAM write address from the write stage
- rd_addr  out  12  capture RAM read address
- ram_q  in  DATA_W  capture RAM read data
- vme_rd  in  1  single-cycle read strobe from the VME slave decoder
- vme_clr  in  1  single-cycle clear/re-arm strobe
- vme_data  out  DATA_W  read data, valid when vme_ack=1
- vme_ack  out  1  one-cycle read acknowledge
- buf_full  out  1  capture complete, unread words available
- busy  out  1  capture in progress
- words_left  out  13  unread words remaining (0..4096)
- err  out  1  sticky protocol error
- checksum  out  16  running sum of delivered words (see Configuration)

## Operation

The block is controlled by a state machine with five states: IDLE, CAPTURE, READY, FETCH, DONE.

- **IDLE:** all counters are 0. When wr_ena=1, go to CAPTURE.
  - Latch first_addr = wr_addr of that cycle.
  - Set cnt = 1.
  - Clear checksum.
- **CAPTURE:** busy=1.
  - Each cycle with wr_ena=1: cnt += 1, saturating at 4096.
  - When wr_ena=0, go to READY.
  - On entry to READY: words_left = cnt, rd_addr = first_addr.
- **READY:** buf_full=1 while words_left>0.
  - vme_rd=1 → go to FETCH and start the latency counter.
- **FETCH:** wait RAM_LAT cycles, then:
  - vme_data = ram_q, vme_ack=1 for one cycle.
  - rd_addr += 1, modulo 4096, so 4095 wraps to 0.
  - words_left -= 1.
  - If words_left becomes 0, go to DONE; otherwise go to READY.
- **DONE:** buf_full=0.
  - vme_rd → vme_ack=1 with vme_data=0, and err=1.
  - wr_ena=1 does **not** auto-rearm; the block stays in DONE until vme_clr.

Error and clear rules:
- vme_rd while in FETCH or CAPTURE: ignored (no ack), err=1.
- vme_rd in IDLE: vme_ack=1 with vme_data=0, err=1.
- wr_ena=1 while in READY or FETCH (a new trigger overwriting unread data): err=1. Readout continues unchanged.
- vme_clr in any state: go to IDLE and clear err, words_left, rd_addr and checksum.
  - vme_clr and vme_rd in the same cycle: clr wins, no ack.
  - vme_clr and wr_ena in the same cycle: go to IDLE. A capture begins only on a wr_ena=1 seen in a later cycle.

## Timing

- Reset (rst=0 at a clk edge) forces IDLE and sets every output to 0: rd_addr, vme_data, vme_ack, buf_full, busy, words_left, err, checksum. Reset overrides every other input, including mid-capture and mid-fetch.
- All outputs are registered.
- Read latency: vme_rd sampled at edge N → vme_ack high in cycle N+RAM_LAT+1.
- Minimum spacing between accepted reads is RAM_LAT+2 cycles.
- rd_addr is stable for the whole FETCH state and updates in the same edge as vme_ack.
- busy falls, and buf_full rises, on the edge after the first sample with wr_ena=0.
- words_left decrements in the same cycle vme_ack is high.

## Configuration

RD_CHECKSUM_EN:
- **Defined:** checksum accumulates checksum + vme_data[15:0] (mod 2^16) on every real data ack (states FETCH→READY/DONE only). It holds its value in DONE until vme_clr or reset.
- **Undefined:** no accumulator logic is built and checksum is tied to 16'h0000.

## Test plan

- **Full capture:** wr_ena high 4096 cycles with wr_addr 1..4095,0; RAM preloaded with word = address → 4096 reads return 1,2,…,4095,0; words_left ends at 0; buf_full falls; err=0.
- **Wrap and short event:** first_addr=4094, 4 words → rd_addr sequence 4094,4095,0,1; DONE after 4 acks.
- **Latency:** RAM_LAT=2 and RAM_LAT=1 → vme_ack exactly 3 and 2 cycles after vme_rd; vme_rd issued during FETCH produces no ack and sets err=1.
- **Over-read and clear:** 5th vme_rd after a 4-word event → ack with vme_data=0, err=1. vme_clr → err=0, IDLE. The next wr_ena burst is captured correctly.
- **Reset mid-fetch:** rst=0 for one cycle during FETCH → no ack, all outputs 0. A new capture and readout then works.
- **Checksum (RD_CHECKSUM_EN defined):** words 16'hFFFF,16'h0002,16'h0010 → checksum 16'h0011. Without the macro, checksum stays 0.
